// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared types and defaults for the cotm32 branch path.
//   bu_op_t         branch compare operation encoding (codes 8..15 undefined)
//   CORE_XLEN       datapath / PC width
//   BPU_ENTRIES     default branch-history-table depth
//   BPU_CNT_BITS    default saturating-counter width
//   is_cond_branch  true for the conditional compares (EQ..GEU), which are
//                   the only ops that train the predictor and count in stats
package cotm32_pkg;

  localparam int CORE_XLEN    = 32;
  localparam int BPU_ENTRIES  = 64;
  localparam int BPU_CNT_BITS = 2;

  typedef enum logic [3:0] {
    BU_ALWAYS = 4'd0,
    BU_NEVER  = 4'd1,
    BU_EQ     = 4'd2,
    BU_NE     = 4'd3,
    BU_LT     = 4'd4,
    BU_GE     = 4'd5,
    BU_LTU    = 4'd6,
    BU_GEU    = 4'd7
  } bu_op_t;

  function automatic logic is_cond_branch(input bu_op_t op);
    case (op)
      BU_EQ, BU_NE, BU_LT, BU_GE, BU_LTU, BU_GEU: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bu.sv
// bu: combinational branch unit; evaluates a branch compare.
//   i_be    in   1      request valid; o_take forced low when clear
//   i_a     in   XLEN   first compare operand
//   i_b     in   XLEN   second compare operand
//   i_op    in   op     compare operation (undefined codes resolve not-taken)
//   o_take  out  1      branch outcome
module bu
  import cotm32_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic            i_be,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  bu_op_t          i_op,
  output logic            o_take
);

  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic                   w_res;

  assign w_a_s = i_a;
  assign w_b_s = i_b;

  always_comb begin
    w_res = 1'b0;
    case (i_op)
      BU_ALWAYS: w_res = 1'b1;
      BU_NEVER:  w_res = 1'b0;
      BU_EQ:     w_res = (i_a == i_b);
      BU_NE:     w_res = (i_a != i_b);
      BU_LT:     w_res = (w_a_s <  w_b_s);
      BU_GE:     w_res = (w_a_s >= w_b_s);
      BU_LTU:    w_res = (i_a <  i_b);
      BU_GEU:    w_res = (i_a >= i_b);
      default:   w_res = 1'b0;
    endcase
  end

  assign o_take = i_be & w_res;

endmodule

// File: rtl/bpu.sv
// bpu: branch prediction and resolution unit.
//   Front end: zero-latency taken/not-taken prediction from a PC-indexed
//   table of saturating counters. Back end: registers the resolved outcome,
//   flags mispredicts, trains the table on conditional branches and keeps
//   branch / mispredict statistics.
//   i_clk         in   1       clock, rising edge
//   i_rst         in   1       async reset, active-high
//   i_pred_pc     in   XLEN    fetch PC to predict
//   o_pred_take   out  1       predicted taken (combinational)
//   i_be          in   1       resolve request valid
//   i_kill        in   1       squash this cycle's resolve
//   i_pc          in   XLEN    PC of the resolving instruction
//   i_a, i_b      in   XLEN    compare operands
//   i_op          in   op      compare operation
//   i_pred_taken  in   1       prediction carried with the instruction
//   o_valid       out  1       registered resolve valid
//   o_take        out  1       registered actual outcome
//   o_mispredict  out  1       registered outcome != carried prediction
//   o_branch_cnt  out  STAT_W  conditional branches resolved (wraps)
//   o_miss_cnt    out  STAT_W  conditional mispredicts (wraps)
module bpu
  import cotm32_pkg::*;
#(
  parameter int XLEN        = CORE_XLEN,
  parameter int BHT_ENTRIES = BPU_ENTRIES,
  parameter int CNT_BITS    = BPU_CNT_BITS,
  parameter int STAT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_pred_pc,
  output logic              o_pred_take,
  input  logic              i_be,
  input  logic              i_kill,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  bu_op_t            i_op,
  input  logic              i_pred_taken,
  output logic              o_valid,
  output logic              o_take,
  output logic              o_mispredict,
  output logic [STAT_W-1:0] o_branch_cnt,
  output logic [STAT_W-1:0] o_miss_cnt
);

  localparam int                IDX_W    = $clog2(BHT_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_MAX >> 1;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    return (c == '0) ? c : c - CNT_BITS'(1);
  endfunction

  logic [CNT_BITS-1:0] r_table [BHT_ENTRIES];

  logic [IDX_W-1:0]    w_pred_idx;
  logic [IDX_W-1:0]    w_train_idx;
  logic                w_accept;
  logic                w_cond;
  logic                w_take;
  logic                w_miss;

  logic                r_vld_p1;
  logic                r_take_p1;
  logic                r_miss_p1;
  logic [STAT_W-1:0]   r_branch_cnt;
  logic [STAT_W-1:0]   r_miss_cnt;

  // Word-aligned index; upper PC bits alias onto the same entries.
  assign w_pred_idx  = i_pred_pc[IDX_W+1:2];
  assign w_train_idx = i_pc[IDX_W+1:2];

  logic w_unused_pc;
  assign w_unused_pc = ^{i_pred_pc[XLEN-1:IDX_W+2], i_pred_pc[1:0],
                         i_pc[XLEN-1:IDX_W+2], i_pc[1:0]};

  // Reads the registered table, so a same-cycle train is not bypassed.
  assign o_pred_take = r_table[w_pred_idx][CNT_BITS-1];

  assign w_accept = i_be & ~i_kill;
  assign w_cond   = is_cond_branch(i_op);

  bu #(
    .XLEN (XLEN)
  ) u_bu (
    .i_be   (1'b1),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_op   (i_op),
    .o_take (w_take)
  );

  assign w_miss = w_take ^ i_pred_taken;

  // ---- stage p0 -> p1: result registration, training, statistics ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_table[i] <= CNT_INIT;
    end else if (w_accept && w_cond) begin
      r_table[w_train_idx] <= w_take ? sat_inc(r_table[w_train_idx])
                                     : sat_dec(r_table[w_train_idx]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_p1  <= 1'b0;
      r_take_p1 <= 1'b0;
      r_miss_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_accept;
      r_take_p1 <= w_accept & w_take;
      r_miss_p1 <= w_accept & w_miss;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (w_accept && w_cond) begin
      r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (w_miss) r_miss_cnt <= r_miss_cnt + STAT_W'(1);
    end
  end

  assign o_valid      = r_vld_p1;
  assign o_take       = r_take_p1;
  assign o_mispredict = r_miss_p1;
  assign o_branch_cnt = r_branch_cnt;
  assign o_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_bpu.sv
module tb_bpu;
  import cotm32_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_take;
  logic        be;
  logic        kill;
  logic [31:0] pc;
  logic [31:0] a;
  logic [31:0] b;
  bu_op_t      op;
  logic        pred_taken;
  logic        valid;
  logic        take;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  bpu dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pred_pc    (pred_pc),
    .o_pred_take  (pred_take),
    .i_be         (be),
    .i_kill       (kill),
    .i_pc         (pc),
    .i_a          (a),
    .i_b          (b),
    .i_op         (op),
    .i_pred_taken (pred_taken),
    .o_valid      (valid),
    .o_take       (take),
    .o_mispredict (mispredict),
    .o_branch_cnt (branch_cnt),
    .o_miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one resolve at the falling edge, let the rising edge register it,
  // then sample 1 time unit later and drop the request.
  task automatic resolve(input logic [31:0] r_pc, input bu_op_t r_op,
                         input logic [31:0] r_a, input logic [31:0] r_b,
                         input logic r_pred, input logic r_kill);
    @(negedge clk);
    be = 1'b1; kill = r_kill; pc = r_pc; op = r_op;
    a = r_a; b = r_b; pred_taken = r_pred;
    @(posedge clk);
    #1;
    be = 1'b0; kill = 1'b0;
  endtask

  task automatic predict(input logic [31:0] p);
    pred_pc = p;
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic t, input logic m);
    chk({tag, ".valid"}, 64'(valid), 64'(v));
    chk({tag, ".take"}, 64'(take), 64'(t));
    chk({tag, ".mispredict"}, 64'(mispredict), 64'(m));
  endtask

  task automatic chk_stats(input string tag, input int br, input int ms);
    chk({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(br));
    chk({tag, ".miss_cnt"}, 64'(miss_cnt), 64'(ms));
  endtask

  initial begin
    rst = 1'b1; be = 1'b0; kill = 1'b0; pc = '0; a = '0; b = '0;
    op = BU_NEVER; pred_taken = 1'b0; pred_pc = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    predict(32'h100);
    chk("rst.pred", 64'(pred_take), 64'd0);
    chk_res("rst", 1'b0, 1'b0, 1'b0);
    chk_stats("rst", 0, 0);

    // 2: two taken EQ at 0x100 with carried prediction not-taken
    predict(32'h100);
    resolve(32'h100, BU_EQ, 32'd5, 32'd5, 1'b0, 1'b0);
    chk_res("eq1", 1'b1, 1'b1, 1'b1);
    predict(32'h100);
    chk("eq1.pred", 64'(pred_take), 64'd1);   // counter 01 -> 10
    resolve(32'h100, BU_EQ, 32'd5, 32'd5, 1'b0, 1'b0);
    chk_res("eq2", 1'b1, 1'b1, 1'b1);
    predict(32'h100);
    chk("eq2.pred", 64'(pred_take), 64'd1);   // counter 10 -> 11
    chk_stats("eq2", 2, 2);

    // idle cycle clears the registered result
    @(posedge clk); #1;
    chk_res("idle", 1'b0, 1'b0, 1'b0);

    // 3: saturation at 0x40 (index 16)
    for (int i = 0; i < 5; i++) resolve(32'h40, BU_EQ, 32'd7, 32'd7, 1'b1, 1'b0);
    chk_res("sat5", 1'b1, 1'b1, 1'b0);
    chk_stats("sat5", 7, 2);
    resolve(32'h40, BU_EQ, 32'd7, 32'd8, 1'b1, 1'b0);
    chk_res("satnt1", 1'b1, 1'b0, 1'b1);
    predict(32'h40);
    chk("satnt1.pred", 64'(pred_take), 64'd1); // 11 -> 10
    resolve(32'h40, BU_EQ, 32'd7, 32'd8, 1'b0, 1'b0);
    predict(32'h40);
    chk("satnt2.pred", 64'(pred_take), 64'd0); // 10 -> 01, so it had saturated at 11
    chk_stats("satnt2", 9, 3);

    // 4: signed vs unsigned compares at 0x0C (index 3) and 0x10 (index 4)
    resolve(32'h0C, BU_LT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    chk_res("lt", 1'b1, 1'b1, 1'b1);
    resolve(32'h0C, BU_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    chk_res("ltu", 1'b1, 1'b0, 1'b0);
    resolve(32'h10, BU_NE, 32'd3, 32'd4, 1'b1, 1'b0);
    chk_res("ne", 1'b1, 1'b1, 1'b0);
    resolve(32'h10, BU_GE, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    chk_res("ge", 1'b1, 1'b0, 1'b0);
    resolve(32'h10, BU_GEU, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    chk_res("geu", 1'b1, 1'b1, 1'b1);
    chk_stats("cmp", 14, 5);

    // unconditional / undefined ops: flag mispredict, never train or count
    resolve(32'h0C, BU_ALWAYS, 32'd0, 32'd0, 1'b0, 1'b0);
    chk_res("always", 1'b1, 1'b1, 1'b1);
    resolve(32'h0C, BU_ALWAYS, 32'd0, 32'd0, 1'b0, 1'b0);
    predict(32'h0C);
    chk("always.pred", 64'(pred_take), 64'd0); // idx 3 stays 01
    resolve(32'h0C, BU_NEVER, 32'd0, 32'd0, 1'b1, 1'b0);
    chk_res("never", 1'b1, 1'b0, 1'b1);
    resolve(32'h0C, bu_op_t'(4'hF), 32'd5, 32'd5, 1'b1, 1'b0);
    chk_res("undef", 1'b1, 1'b0, 1'b1);
    chk_stats("uncond", 14, 5);

    // 5: kill squashes the request at 0x80 (index 32)
    resolve(32'h80, BU_EQ, 32'd1, 32'd1, 1'b0, 1'b1);
    chk_res("kill", 1'b0, 1'b0, 1'b0);
    chk_stats("kill", 14, 5);
    predict(32'h80);
    chk("kill.pred", 64'(pred_take), 64'd0);

    // same-cycle predict and train at 0x80: old value until the next cycle
    @(negedge clk);
    be = 1'b1; kill = 1'b0; pc = 32'h80; op = BU_EQ; a = 32'd1; b = 32'd1;
    pred_taken = 1'b0; pred_pc = 32'h80;
    #1;
    chk("bypass.pre", 64'(pred_take), 64'd0);
    @(posedge clk); #1;
    be = 1'b0;
    chk("bypass.post", 64'(pred_take), 64'd1);

    // 6: asynchronous reset while a result is valid and counters trained
    resolve(32'h80, BU_EQ, 32'd1, 32'd1, 1'b1, 1'b0);
    chk("prerst.valid", 64'(valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_res("arst", 1'b0, 1'b0, 1'b0);
    chk_stats("arst", 0, 0);
    predict(32'h80);
    chk("arst.pred80", 64'(pred_take), 64'd0);
    predict(32'h100);
    chk("arst.pred100", 64'(pred_take), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // one taken train must flip it: entry is weakly, not strongly, not-taken
    resolve(32'h80, BU_EQ, 32'd2, 32'd2, 1'b0, 1'b0);
    predict(32'h80);
    chk("arst.weak", 64'(pred_take), 64'd1);
    chk_stats("arst.after", 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
